// File: rtl/mem_resp.sv
// Byte-wide memory/IO responder: byte RAM plus a memory-mapped RX/TX FIFO window.
// Read data returns on d_out one cycle after the address is presented.

module mem_resp_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Callers pre-qualify push/pop against full/empty; pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

module mem_resp #(
  parameter int          ADDR_W     = 17,
  parameter logic [31:0] IO_ADDR    = 32'h0003_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a_in,
  input  logic        wr_in,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  input  logic        io_rx_valid,
  input  logic [7:0]  io_rx_data,
  output logic        io_rx_ready,
  output logic        io_tx_valid,
  output logic [7:0]  io_tx_data,
  input  logic        io_tx_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [7:0] ram_q [2**ADDR_W];

  logic [7:0]    d_out_q, d_out_d;
  logic          tx_ovf_q, tx_ovf_d;
  logic          last_io_rd_q, last_io_rd_d;

  logic          sel_data, sel_stat, sel_ram;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [7:0]    rx_head, tx_head;
  logic          rx_full, rx_empty, tx_full, tx_empty;
  logic          rx_push, rx_pop, tx_push, tx_pop, tx_push_req;

  assign sel_data = (a_in == IO_ADDR);
  assign sel_stat = (a_in == (IO_ADDR + 32'd4));
  assign sel_ram  = !sel_data && !sel_stat;

  assign rx_full  = (rx_cnt == FULL_CNT);
  assign rx_empty = (rx_cnt == '0);
  assign tx_full  = (tx_cnt == FULL_CNT);
  assign tx_empty = (tx_cnt == '0);

  // Both host ports use valid/ready: a byte moves on any edge where valid && ready.
  assign rx_push     = io_rx_valid && !rx_full;
  assign rx_pop      = sel_data && !wr_in && !last_io_rd_q && !rx_empty;
  assign tx_pop      = !tx_empty && io_tx_ready;
  assign tx_push_req = sel_data && wr_in;
  // A full TX still accepts a push when the host drains the head the same edge.
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);

  mem_resp_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .din_i   (io_rx_data),
    .head_o  (rx_head),
    .count_o (rx_cnt)
  );

  mem_resp_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .din_i   (d_in),
    .head_o  (tx_head),
    .count_o (tx_cnt)
  );

  always_comb begin
    d_out_d      = d_out_q;
    tx_ovf_d     = tx_ovf_q;
    last_io_rd_d = sel_data && !wr_in;
    if (tx_push_req && tx_full && !tx_pop) tx_ovf_d = 1'b1;
    if (sel_stat && wr_in) tx_ovf_d = 1'b0;
    if (!wr_in) begin
      if (sel_data) begin
        // Only the first cycle of a continuous IO_DATA read run pops RX.
        if (!last_io_rd_q) d_out_d = rx_empty ? 8'h00 : rx_head;
      end else if (sel_stat) begin
        d_out_d = {5'b0, tx_ovf_q, tx_full, !rx_empty};
      end else begin
        d_out_d = ram_q[a_in[ADDR_W-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_out_q      <= 8'h00;
      tx_ovf_q     <= 1'b0;
      last_io_rd_q <= 1'b0;
    end else begin
      d_out_q      <= d_out_d;
      tx_ovf_q     <= tx_ovf_d;
      last_io_rd_q <= last_io_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_in && sel_ram) ram_q[a_in[ADDR_W-1:0]] <= d_in;
  end

  assign d_out       = d_out_q;
  assign io_rx_ready = !rx_full;
  assign io_tx_valid = !tx_empty;
  assign io_tx_data  = tx_empty ? 8'h00 : tx_head;

endmodule

// File: tb/tb_mem_resp.sv
// Directed bench for mem_resp: RAM path, address wrap, TX/RX FIFOs and async reset.
// Inputs change 1 time unit after a rising edge; outputs are checked at that point too.

module tb_mem_resp;

  localparam logic [31:0] IO_DATA = 32'h0003_0000;
  localparam logic [31:0] IO_STAT = 32'h0003_0004;
  localparam logic [31:0] IDLE_A  = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic [31:0] a_in;
  logic        wr_in;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic        io_rx_valid;
  logic [7:0]  io_rx_data;
  logic        io_rx_ready;
  logic        io_tx_valid;
  logic [7:0]  io_tx_data;
  logic        io_tx_ready;

  int vectors = 0;
  int errors  = 0;

  mem_resp #(.ADDR_W(17), .IO_ADDR(32'h0003_0000), .FIFO_DEPTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .a_in        (a_in),
    .wr_in       (wr_in),
    .d_in        (d_in),
    .d_out       (d_out),
    .io_rx_valid (io_rx_valid),
    .io_rx_data  (io_rx_data),
    .io_rx_ready (io_rx_ready),
    .io_tx_valid (io_tx_valid),
    .io_tx_data  (io_tx_data),
    .io_tx_ready (io_tx_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [31:0] a, input logic w, input logic [7:0] d);
    a_in  = a;
    wr_in = w;
    d_in  = d;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    bus(IDLE_A, 1'b0, 8'h00);
    io_rx_valid = 1'b0;
    io_rx_data  = 8'h00;
    io_tx_ready = 1'b0;
    #1;
    check("rst d_out", d_out, 8'h00);
    check("rst rx_ready", {7'b0, io_rx_ready}, 8'h01);
    check("rst tx_valid", {7'b0, io_tx_valid}, 8'h00);
    check("rst tx_data", io_tx_data, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    #1;

    // RAM round trip, write holds d_out, read-after-write
    bus(32'h10, 1'b1, 8'hA5); tick();
    bus(32'h11, 1'b1, 8'h3C); tick();
    bus(32'h10, 1'b0, 8'h00); tick();
    check("ram rd 0x10", d_out, 8'hA5);
    bus(32'h11, 1'b0, 8'h00); tick();
    check("ram rd 0x11", d_out, 8'h3C);
    bus(32'h12, 1'b1, 8'h99); tick();
    check("ram wr holds d_out", d_out, 8'h3C);
    bus(32'h12, 1'b0, 8'h00); tick();
    check("ram raw 0x12", d_out, 8'h99);

    // address wrap
    bus(32'h0002_0005, 1'b1, 8'h77); tick();
    bus(32'h5, 1'b0, 8'h00); tick();
    check("ram wrap", d_out, 8'h77);

    // TX fill past full with host stalled
    for (int i = 1; i <= 9; i++) begin
      bus(IO_DATA, 1'b1, 8'(i)); tick();
    end
    check("tx valid full", {7'b0, io_tx_valid}, 8'h01);
    check("tx head", io_tx_data, 8'h01);
    bus(IO_STAT, 1'b0, 8'h00); tick();
    check("stat ovf full", d_out, 8'h06);
    bus(IDLE_A, 1'b0, 8'h00);
    io_tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("tx drain %0d", i), io_tx_data, 8'(i));
      tick();
    end
    io_tx_ready = 1'b0;
    check("tx empty valid", {7'b0, io_tx_valid}, 8'h00);
    bus(IO_STAT, 1'b1, 8'h00); tick();
    bus(IO_STAT, 1'b0, 8'h00); tick();
    check("stat ovf cleared", d_out, 8'h00);

    // RX single pop per read run
    io_rx_valid = 1'b1; io_rx_data = 8'h41; tick();
    io_rx_data = 8'h42; tick();
    io_rx_valid = 1'b0;
    bus(IO_DATA, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rx run1 c%0d", i), d_out, 8'h41);
    end
    bus(32'h0, 1'b0, 8'h00); tick();
    bus(IO_STAT, 1'b0, 8'h00); tick();
    check("stat rx one left", d_out, 8'h01);
    bus(IO_DATA, 1'b0, 8'h00); tick();
    check("rx run2", d_out, 8'h42);
    tick();
    check("rx run2 hold", d_out, 8'h42);
    bus(IO_STAT, 1'b0, 8'h00); tick();
    check("stat rx empty", d_out, 8'h00);
    bus(IO_DATA, 1'b0, 8'h00); tick();
    check("rx run3 empty", d_out, 8'h00);

    // push into empty RX during a pop cycle: read returns 0, byte stays queued
    bus(32'h0, 1'b0, 8'h00); tick();
    bus(IO_DATA, 1'b0, 8'h00);
    io_rx_valid = 1'b1; io_rx_data = 8'h55; tick();
    io_rx_valid = 1'b0;
    check("rx push+rd empty", d_out, 8'h00);
    bus(IO_STAT, 1'b0, 8'h00); tick();
    check("stat rx queued", d_out, 8'h01);
    bus(IO_DATA, 1'b0, 8'h00); tick();
    check("rx queued byte", d_out, 8'h55);
    bus(IDLE_A, 1'b0, 8'h00); tick();

    // RX backpressure
    io_rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rx ready %0d", i), {7'b0, io_rx_ready}, 8'h01);
      io_rx_data = 8'(8'h60 + i);
      tick();
    end
    check("rx ready full", {7'b0, io_rx_ready}, 8'h00);
    io_rx_data = 8'hEE; tick();
    check("rx ready still full", {7'b0, io_rx_ready}, 8'h00);
    io_rx_valid = 1'b0;
    bus(IO_DATA, 1'b0, 8'h00); tick();
    check("rx bp pop", d_out, 8'h60);
    check("rx ready after pop", {7'b0, io_rx_ready}, 8'h01);
    for (int i = 1; i < 8; i++) begin
      bus(32'h0, 1'b0, 8'h00); tick();
      bus(IO_DATA, 1'b0, 8'h00); tick();
      check($sformatf("rx bp drain %0d", i), d_out, 8'(8'h60 + i));
    end
    bus(32'h0, 1'b0, 8'h00); tick();
    bus(IO_DATA, 1'b0, 8'h00); tick();
    check("rx 9th dropped", d_out, 8'h00);

    // async reset with TX holding bytes
    bus(32'h200, 1'b1, 8'hC3); tick();
    for (int i = 0; i < 3; i++) begin
      bus(IO_DATA, 1'b1, 8'(8'hB0 + i)); tick();
    end
    bus(32'h200, 1'b0, 8'h00); tick();
    check("pre-rst d_out", d_out, 8'hC3);
    check("pre-rst tx_valid", {7'b0, io_tx_valid}, 8'h01);
    #2;
    rst = 1'b0;
    #1;
    check("async rst tx_valid", {7'b0, io_tx_valid}, 8'h00);
    check("async rst d_out", d_out, 8'h00);
    check("async rst tx_data", io_tx_data, 8'h00);
    #4;
    rst = 1'b1;
    tick();
    check("ram survives rst", d_out, 8'hC3);
    check("tx empty after rst", {7'b0, io_tx_valid}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
